rnn_seq_engine: RTL and testbench

// Parametrised successor to the single-step RNN accelerator; same memory-mapped slave bus.

---
 rtl/rnn_seq_engine_if.sv | 33 +++
 rtl/rnn_seq_engine.sv | 390 +++++++++++++++++++++++++++++++++++++++
 tb/tb_rnn_seq_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rnn_seq_engine_if.sv
// ---------------------------------------------------------------------------
// rnn_seq_engine_if
// Memory-mapped slave bus used to program and read back the RNN sequence
// engine.
//   read      1   read strobe (driven by master)
//   write     1   write strobe (driven by master)
//   addr      32  word address (driven by master)
//   data_in   32  write data: [15:0] value, [31:24] row/step, [23:16] col/index
//   data_out  32  read data (driven by slave), combinational, 0 when not reading
// ---------------------------------------------------------------------------
interface rnn_seq_engine_if;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output read,
        output write,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  read,
        input  write,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/rnn_seq_engine.sv
// ---------------------------------------------------------------------------
// rnn_seq_engine
// Autonomous RNN sequence engine. For every step t of a programmed sequence it
// computes h = act(B + x_t*W + h*U) one hidden element at a time on a single
// shared signed MAC, then finishes with a dense output y = D.h + DB.
// Values are signed 16-bit fixed point with FRAC_BITS fractional bits; the
// accumulator is ACC_W bits wide and results are rescaled and saturated.
//
// Ports
//   clk     clock
//   rst_n   asynchronous active-low reset (clears all state, aborts a run)
//   bus     slave side of rnn_seq_engine_if (read/write/addr/data_in/data_out)
//
// Address map
//   0 CTRL   wr: [7:0] seq_len, [8] clear_h, [9] act_mode
//            rd: {29'b0, err, done, busy}, read clears err
//   1 X[step][idx]  2 W[emb][hid]  3 U[hid][hid]  4 B[idx]  5 D[idx]  6 DB
//   7 RESULT rd: y, read clears done
//   8 HPTR   wr: [23:16] h pointer; rd: h[ptr]
// ---------------------------------------------------------------------------
module rnn_seq_engine #(
    parameter int EMB_LEN   = 4,
    parameter int HID_LEN   = 8,
    parameter int SEQ_DEPTH = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    rnn_seq_engine_if.slave   bus
);

    localparam int EW = (EMB_LEN   > 1) ? $clog2(EMB_LEN)   : 1;
    localparam int HW = (HID_LEN   > 1) ? $clog2(HID_LEN)   : 1;
    localparam int SW = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1;

    // Dimensions as 9-bit values so an 8-bit bus index compares cleanly.
    localparam logic [8:0] EMB_DIM = 9'(EMB_LEN);
    localparam logic [8:0] HID_DIM = 9'(HID_LEN);
    localparam logic [8:0] SEQ_DIM = 9'(SEQ_DEPTH);

    localparam logic [EW-1:0] I_LAST = EW'(EMB_LEN - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HID_LEN - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    localparam logic signed [15:0] ONE_Q     = 16'sd1 <<< FRAC_BITS;
    localparam logic signed [15:0] NEG_ONE_Q = -ONE_Q;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INIT   = 4'd1,
        ST_MAC_X  = 4'd2,
        ST_MAC_H  = 4'd3,
        ST_WB     = 4'd4,
        ST_SWAP   = 4'd5,
        ST_D_INIT = 4'd6,
        ST_D_MAC  = 4'd7,
        ST_D_WB   = 4'd8
    } state_t;

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    // Rescale the accumulator (floor shift) and clamp to signed 16 bits.
    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] a);
        logic signed [15:0] r;
        if ((a >>> FRAC_BITS) > SAT_MAX) begin
            r = 16'sh7FFF;
        end else if ((a >>> FRAC_BITS) < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = 16'(a >>> FRAC_BITS);
        end
        return r;
    endfunction

    // Hard tanh clamps to [-1.0, +1.0]; mode 0 passes the value through.
    function automatic logic signed [15:0] act(input logic signed [15:0] v,
                                               input logic               mode);
        logic signed [15:0] r;
        if (mode && (v > ONE_Q)) begin
            r = ONE_Q;
        end else if (mode && (v < NEG_ONE_Q)) begin
            r = NEG_ONE_Q;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [15:0]      x_mem_r [SEQ_DEPTH][EMB_LEN];
    logic signed [15:0]      w_mem_r [EMB_LEN][HID_LEN];
    logic signed [15:0]      u_mem_r [HID_LEN][HID_LEN];
    logic signed [15:0]      b_mem_r [HID_LEN];
    logic signed [15:0]      d_mem_r [HID_LEN];
    logic signed [15:0]      db_r;
    logic signed [15:0]      h_r     [HID_LEN];
    logic signed [15:0]      hn_r    [HID_LEN];
    logic signed [15:0]      y_r;
    logic signed [ACC_W-1:0] acc_r;

    logic [HW-1:0] ptr_r;
    logic [7:0]    seq_len_r;
    logic          act_mode_r;
    logic          busy_r;
    logic          done_r;
    logic          err_r;

    state_t        state_r;
    state_t        state_s;
    logic [EW-1:0] i_r;
    logic [HW-1:0] k_r;
    logic [HW-1:0] j_r;
    logic [7:0]    t_r;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [7:0]         row_s;
    logic [7:0]         col_s;
    logic signed [15:0] val_s;
    logic [7:0]         ctrl_len_s;
    logic               idx_ok_s;
    logic               wr_arr_s;
    logic               wr_ctrl_s;
    logic               wr_hptr_s;
    logic               len_bad_s;
    logic               err_set_s;
    logic               start_s;
    logic               arr_we_s;

    assign row_s      = bus.data_in[31:24];
    assign col_s      = bus.data_in[23:16];
    assign val_s      = bus.data_in[15:0];
    assign ctrl_len_s = bus.data_in[7:0];

    // Range check of the row/col fields against the addressed array.
    always_comb begin
        idx_ok_s = 1'b1;
        case (bus.addr)
            32'd1:   idx_ok_s = ({1'b0, row_s} < SEQ_DIM) && ({1'b0, col_s} < EMB_DIM);
            32'd2:   idx_ok_s = ({1'b0, row_s} < EMB_DIM) && ({1'b0, col_s} < HID_DIM);
            32'd3:   idx_ok_s = ({1'b0, row_s} < HID_DIM) && ({1'b0, col_s} < HID_DIM);
            32'd4:   idx_ok_s = ({1'b0, col_s} < HID_DIM);
            32'd5:   idx_ok_s = ({1'b0, col_s} < HID_DIM);
            32'd8:   idx_ok_s = ({1'b0, col_s} < HID_DIM);
            default: idx_ok_s = 1'b1;
        endcase
    end

    assign wr_arr_s  = bus.write && (bus.addr >= 32'd1) && (bus.addr <= 32'd6);
    assign wr_ctrl_s = bus.write && (bus.addr == 32'd0);
    assign wr_hptr_s = bus.write && (bus.addr == 32'd8);
    assign len_bad_s = (ctrl_len_s == 8'd0) || ({1'b0, ctrl_len_s} > SEQ_DIM);

    // An illegal access only raises err; it never changes any other state.
    assign err_set_s = (wr_arr_s  && (busy_r || !idx_ok_s))
                     || (wr_ctrl_s && (busy_r || len_bad_s))
                     || (wr_hptr_s && !idx_ok_s);
    assign start_s   = wr_ctrl_s && !busy_r && !len_bad_s;
    assign arr_we_s  = wr_arr_s  && !busy_r && idx_ok_s;

    // Read mux: combinational so a same-cycle write is not yet visible.
    always_comb begin
        bus.data_out = 32'd0;
        if (bus.read) begin
            case (bus.addr)
                32'd0:   bus.data_out = {29'd0, err_r, done_r, busy_r};
                32'd7:   bus.data_out = {{16{y_r[15]}}, y_r};
                32'd8:   bus.data_out = {{16{h_r[ptr_r][15]}}, h_r[ptr_r]};
                default: bus.data_out = 32'd0;
            endcase
        end else begin
            bus.data_out = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------
    // Status flags, run configuration and the h read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            ptr_r      <= '0;
            seq_len_r  <= 8'd0;
            act_mode_r <= 1'b0;
        end else begin
            if (start_s) begin
                busy_r     <= 1'b1;
                done_r     <= 1'b0;
                seq_len_r  <= ctrl_len_s;
                act_mode_r <= bus.data_in[9];
            end else if (state_r == ST_D_WB) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else if (bus.read && (bus.addr == 32'd7)) begin
                done_r <= 1'b0;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (bus.read && (bus.addr == 32'd0)) begin
                err_r <= 1'b0;
            end
            if (wr_hptr_s && idx_ok_s) begin
                ptr_r <= col_s[HW-1:0];
            end
        end
    end

    // Parameter arrays, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SEQ_DEPTH; s++) begin
                for (int e = 0; e < EMB_LEN; e++) begin
                    x_mem_r[s][e] <= 16'sd0;
                end
            end
            for (int e = 0; e < EMB_LEN; e++) begin
                for (int n = 0; n < HID_LEN; n++) begin
                    w_mem_r[e][n] <= 16'sd0;
                end
            end
            for (int m = 0; m < HID_LEN; m++) begin
                for (int n = 0; n < HID_LEN; n++) begin
                    u_mem_r[m][n] <= 16'sd0;
                end
                b_mem_r[m] <= 16'sd0;
                d_mem_r[m] <= 16'sd0;
            end
            db_r <= 16'sd0;
        end else if (arr_we_s) begin
            case (bus.addr)
                32'd1:   x_mem_r[row_s[SW-1:0]][col_s[EW-1:0]] <= val_s;
                32'd2:   w_mem_r[row_s[EW-1:0]][col_s[HW-1:0]] <= val_s;
                32'd3:   u_mem_r[row_s[HW-1:0]][col_s[HW-1:0]] <= val_s;
                32'd4:   b_mem_r[col_s[HW-1:0]] <= val_s;
                32'd5:   d_mem_r[col_s[HW-1:0]] <= val_s;
                32'd6:   db_r <= val_s;
                default: db_r <= db_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic i_last_s;
    logic k_last_s;
    logic j_last_s;
    logic t_last_s;

    assign i_last_s = (i_r == I_LAST);
    assign k_last_s = (k_r == H_LAST);
    assign j_last_s = (j_r == H_LAST);
    assign t_last_s = (t_r == (seq_len_r - 8'd1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = start_s ? ST_INIT : ST_IDLE;
            ST_INIT:   state_s = ST_MAC_X;
            ST_MAC_X:  state_s = i_last_s ? ST_MAC_H : ST_MAC_X;
            ST_MAC_H:  state_s = k_last_s ? ST_WB : ST_MAC_H;
            ST_WB:     state_s = j_last_s ? ST_SWAP : ST_INIT;
            ST_SWAP:   state_s = t_last_s ? ST_D_INIT : ST_INIT;
            ST_D_INIT: state_s = ST_D_MAC;
            ST_D_MAC:  state_s = k_last_s ? ST_D_WB : ST_D_MAC;
            ST_D_WB:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Loop counters: i over inputs, k over hidden terms, j over outputs, t over steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r <= '0;
            k_r <= '0;
            j_r <= '0;
            t_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        j_r <= '0;
                        t_r <= 8'd0;
                    end
                end
                ST_INIT: begin
                    i_r <= '0;
                    k_r <= '0;
                end
                ST_MAC_X: i_r <= i_r + EW'(1);
                ST_MAC_H: k_r <= k_r + HW'(1);
                ST_WB:    j_r <= j_last_s ? '0 : (j_r + HW'(1));
                ST_SWAP:  t_r <= t_r + 8'd1;
                ST_D_INIT: k_r <= '0;
                ST_D_MAC: k_r <= k_r + HW'(1);
                default:  t_r <= t_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: one shared 16x16 signed multiplier feeding the accumulator
    // ------------------------------------------------------------------
    logic signed [15:0] mul_a_s;
    logic signed [15:0] mul_b_s;
    logic signed [31:0] prod_s;

    // Operand selection for the shared multiplier.
    always_comb begin
        mul_a_s = 16'sd0;
        mul_b_s = 16'sd0;
        case (state_r)
            ST_MAC_X: begin
                mul_a_s = x_mem_r[t_r[SW-1:0]][i_r];
                mul_b_s = w_mem_r[i_r][j_r];
            end
            ST_MAC_H: begin
                mul_a_s = h_r[k_r];
                mul_b_s = u_mem_r[k_r][j_r];
            end
            ST_D_MAC: begin
                mul_a_s = d_mem_r[k_r];
                mul_b_s = h_r[k_r];
            end
            default: begin
                mul_a_s = 16'sd0;
                mul_b_s = 16'sd0;
            end
        endcase
    end

    assign prod_s = 32'(mul_a_s) * 32'(mul_b_s);

    // Accumulator, next-state buffer hn, hidden state h and dense result y.
    // hn holds the new hidden vector so MAC_H keeps reading the old h until SWAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            y_r   <= 16'sd0;
            for (int m = 0; m < HID_LEN; m++) begin
                h_r[m]  <= 16'sd0;
                hn_r[m] <= 16'sd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s && bus.data_in[8]) begin
                        for (int m = 0; m < HID_LEN; m++) begin
                            h_r[m] <= 16'sd0;
                        end
                    end
                end
                ST_INIT:   acc_r <= {{(ACC_W-16){b_mem_r[j_r][15]}}, b_mem_r[j_r]} <<< FRAC_BITS;
                ST_MAC_X,
                ST_MAC_H,
                ST_D_MAC:  acc_r <= acc_r + {{(ACC_W-32){prod_s[31]}}, prod_s};
                ST_WB:     hn_r[j_r] <= act(sat16(acc_r), act_mode_r);
                ST_SWAP: begin
                    for (int m = 0; m < HID_LEN; m++) begin
                        h_r[m] <= hn_r[m];
                    end
                end
                ST_D_INIT: acc_r <= {{(ACC_W-16){db_r[15]}}, db_r} <<< FRAC_BITS;
                ST_D_WB:   y_r <= sat16(acc_r);
                default:   acc_r <= acc_r;
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_seq_engine.sv
module tb_rnn_seq_engine;

    localparam int E = 4;
    localparam int H = 8;
    localparam int S = 16;
    localparam int F = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rnn_seq_engine_if bus_if();

    rnn_seq_engine #(
        .EMB_LEN  (E),
        .HID_LEN  (H),
        .SEQ_DEPTH(S),
        .FRAC_BITS(F),
        .ACC_W    (40)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    // Reference state kept by the bench.
    logic signed [15:0] mx [S][E];
    logic signed [15:0] mw [E][H];
    logic signed [15:0] mu [H][H];
    logic signed [15:0] mb [H];
    logic signed [15:0] md [H];
    logic signed [15:0] mdb;
    logic signed [15:0] mh [H];
    logic signed [15:0] my;

    int n_vec  = 0;
    int n_fail = 0;
    logic [15:0] g_h0;
    logic [15:0] g_y;
    int          g_cyc;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d, logic [31:0] x);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = x;
        return v;
    endfunction

    function automatic logic [31:0] pack(int r, int c, logic [15:0] v);
        return {8'(r), 8'(c), v};
    endfunction

    function automatic logic [31:0] sx(logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] ctrl(int sl, bit ch, bit am);
        return {22'd0, am, ch, 8'(sl)};
    endfunction

    function automatic logic signed [15:0] m_sat(longint v);
        longint q;
        q = v >>> F;
        if (q > 32767) return 16'sh7FFF;
        if (q < -32768) return 16'sh8000;
        return 16'(q);
    endfunction

    function automatic logic signed [15:0] m_act(logic signed [15:0] v, bit mode);
        if (!mode) return v;
        if (v > 256) return 16'sd256;
        if (v < -256) return -16'sd256;
        return v;
    endfunction

    function automatic logic [15:0] rv();
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        return 16'(int'($urandom_range(0, 1023)) - 512);
    endfunction

    // Whole-sequence reference: h = act(B + x*W + h*U) per step, then y = D.h + DB.
    task automatic model_run(int sl, bit ch, bit am);
        logic signed [15:0] hn [H];
        longint acc;
        if (ch) for (int j = 0; j < H; j++) mh[j] = 16'sd0;
        for (int t = 0; t < sl; t++) begin
            for (int j = 0; j < H; j++) begin
                acc = longint'(mb[j]) * (longint'(1) << F);
                for (int i = 0; i < E; i++) acc += longint'(mx[t][i]) * longint'(mw[i][j]);
                for (int k = 0; k < H; k++) acc += longint'(mh[k]) * longint'(mu[k][j]);
                hn[j] = m_act(m_sat(acc), am);
            end
            for (int j = 0; j < H; j++) mh[j] = hn[j];
        end
        acc = longint'(mdb) * (longint'(1) << F);
        for (int k = 0; k < H; k++) acc += longint'(md[k]) * longint'(mh[k]);
        my = m_sat(acc);
    endtask

    task automatic model_clear();
        for (int s = 0; s < S; s++) for (int e = 0; e < E; e++) mx[s][e] = 16'sd0;
        for (int e = 0; e < E; e++) for (int n = 0; n < H; n++) mw[e][n] = 16'sd0;
        for (int m = 0; m < H; m++) begin
            for (int n = 0; n < H; n++) mu[m][n] = 16'sd0;
            mb[m] = 16'sd0; md[m] = 16'sd0; mh[m] = 16'sd0;
        end
        mdb = 16'sd0;
        my  = 16'sd0;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_wr(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        bus_if.write = 1'b1; bus_if.read = 1'b0; bus_if.addr = a; bus_if.data_in = d;
        @(posedge clk);
        #1 bus_if.write = 1'b0;
    endtask

    task automatic bus_rd(logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.read = 1'b1; bus_if.write = 1'b0; bus_if.addr = a;
        #1 d = bus_if.data_out;
        @(posedge clk);
        #1 bus_if.read = 1'b0;
    endtask

    task automatic bus_rdwr(logic [31:0] a, logic [31:0] wd, output logic [31:0] d);
        @(negedge clk);
        bus_if.read = 1'b1; bus_if.write = 1'b1; bus_if.addr = a; bus_if.data_in = wd;
        #1 d = bus_if.data_out;
        @(posedge clk);
        #1 begin bus_if.read = 1'b0; bus_if.write = 1'b0; end
    endtask

    task automatic set_arr(int a, int r, int c, logic [15:0] v);
        bus_wr(32'(a), pack(r, c, v));
        case (a)
            1: mx[r][c] = v;
            2: mw[r][c] = v;
            3: mu[r][c] = v;
            4: mb[c] = v;
            5: md[c] = v;
            6: mdb = v;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.read = 1'b0; bus_if.write = 1'b0; bus_if.addr = 32'd0; bus_if.data_in = 32'd0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start a run, time busy via status polls, then check y, done-clear and all of h.
    task automatic run_check(string tag, int sl, bit ch, bit am);
        logic [31:0] d;
        int cyc, exp_cyc;
        bus_wr(32'd0, ctrl(sl, ch, am));
        model_run(sl, ch, am);
        exp_cyc = sl * (H * (E + H + 2) + 1) + H + 2;
        cyc = 0;
        bus_rd(32'd0, d);
        while (d[0] === 1'b1 && cyc < exp_cyc + 100) begin
            cyc++;
            bus_rd(32'd0, d);
        end
        g_cyc = cyc;
        check({tag, "_busy"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_status"}, d, 32'h2);
        bus_rd(32'd7, d);
        check({tag, "_y"}, d, sx(my));
        g_y = d[15:0];
        bus_rd(32'd0, d);
        check({tag, "_doneclr"}, d, 32'h0);
        for (int j = 0; j < H; j++) begin
            bus_wr(32'd8, pack(0, j, 16'h0));
            bus_rd(32'd8, d);
            check($sformatf("%s_h%0d", tag, j), d, sx(mh[j]));
            if (j == 0) g_h0 = d[15:0];
        end
    endtask

    initial begin
        logic [31:0] d;
        int cyc;

        rst_n = 1'b0;
        bus_if.read = 1'b0; bus_if.write = 1'b0; bus_if.addr = 32'd0; bus_if.data_in = 32'd0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, illegal accesses and read-side corner cases.
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h0));
        tbl.push_back(mk(1'b0, 32'd7,  32'd0, 32'h0));
        tbl.push_back(mk(1'b0, 32'd8,  32'd0, 32'h0));
        tbl.push_back(mk(1'b1, 32'd0,  32'h100, 32'h0));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h4));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h0));
        tbl.push_back(mk(1'b1, 32'd0,  32'h111, 32'h0));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h4));
        tbl.push_back(mk(1'b1, 32'd1,  pack(0, 4, 16'h1234), 32'h0));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h4));
        tbl.push_back(mk(1'b1, 32'd1,  pack(16, 0, 16'h0001), 32'h0));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h4));
        tbl.push_back(mk(1'b1, 32'd8,  pack(0, 8, 16'h0), 32'h0));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h4));
        tbl.push_back(mk(1'b1, 32'd4,  pack(0, 8, 16'h0001), 32'h0));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h4));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h0));
        tbl.push_back(mk(1'b1, 32'd2,  pack(0, 0, 16'h1234), 32'h0));
        tbl.push_back(mk(1'b0, 32'd2,  32'd0, 32'h0));
        tbl.push_back(mk(1'b0, 32'd0,  32'd0, 32'h0));
        tbl.push_back(mk(1'b0, 32'd12, 32'd0, 32'h0));
        foreach (tbl[n]) begin
            if (tbl[n].wr) begin
                bus_wr(tbl[n].addr, tbl[n].data);
            end else begin
                bus_rd(tbl[n].addr, d);
                check($sformatf("tbl%0d", n), d, tbl[n].exp);
            end
        end

        // Single step, single input.
        do_reset();
        set_arr(2, 0, 0, 16'h0100);
        set_arr(1, 0, 0, 16'h0080);
        set_arr(5, 0, 0, 16'h0200);
        set_arr(6, 0, 0, 16'h0010);
        run_check("t1", 1, 1'b1, 1'b0);
        check("t1_busy123", 32'(g_cyc), 32'd123);
        check("t1_h0val", {16'd0, g_h0}, 32'h0080);
        check("t1_yval", {16'd0, g_y}, 32'h0110);
        @(negedge clk);
        bus_if.addr = 32'd7;
        #1 check("noread_dout", bus_if.data_out, 32'h0);

        // Recurrence over three steps, then carry-over of h without clear.
        do_reset();
        set_arr(4, 0, 0, 16'h0040);
        set_arr(3, 0, 0, 16'h0100);
        set_arr(5, 0, 0, 16'h0100);
        run_check("t2", 3, 1'b1, 1'b0);
        check("t2_busy", 32'(g_cyc), 32'd349);
        check("t2_h0val", {16'd0, g_h0}, 32'h00C0);
        check("t2_yval", {16'd0, g_y}, 32'h00C0);
        run_check("t5", 3, 1'b0, 1'b0);
        check("t5_h0val", {16'd0, g_h0}, 32'h0180);

        // Same-cycle read and write of HPTR returns h at the old pointer (7).
        bus_rdwr(32'd8, pack(0, 0, 16'h0), d);
        check("rdwr_old", d, sx(mh[7]));
        bus_rd(32'd8, d);
        check("rdwr_new", d, sx(mh[0]));

        // Reset asserted mid-MAC_H aborts everything.
        bus_wr(32'd0, ctrl(3, 1'b0, 1'b0));
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_rd(32'd0, d); check("abort_status", d, 32'h0);
        bus_rd(32'd7, d); check("abort_result", d, 32'h0);
        bus_rd(32'd8, d); check("abort_hptr", d, 32'h0);
        set_arr(4, 0, 0, 16'h0040);
        set_arr(3, 0, 0, 16'h0100);
        set_arr(5, 0, 0, 16'h0100);
        run_check("fresh", 2, 1'b1, 1'b0);
        check("fresh_h0val", {16'd0, g_h0}, 32'h0080);

        // Saturation and hard tanh.
        do_reset();
        set_arr(1, 0, 0, 16'h7FFF);
        set_arr(2, 0, 0, 16'h7FFF);
        run_check("t3a", 1, 1'b1, 1'b0);
        check("t3a_h0val", {16'd0, g_h0}, 32'h7FFF);
        run_check("t3b", 1, 1'b1, 1'b1);
        check("t3b_h0val", {16'd0, g_h0}, 32'h0100);
        set_arr(2, 0, 0, 16'h8001);
        run_check("t3c", 1, 1'b1, 1'b1);
        check("t3c_h0val", {16'd0, g_h0}, 32'hFF00);

        // Writes during busy are rejected and flagged; the run is unaffected.
        do_reset();
        set_arr(2, 0, 0, 16'h0100);
        set_arr(1, 0, 0, 16'h0080);
        set_arr(5, 0, 0, 16'h0200);
        set_arr(6, 0, 0, 16'h0010);
        bus_wr(32'd0, ctrl(1, 1'b1, 1'b0));
        model_run(1, 1'b1, 1'b0);
        bus_wr(32'd3, pack(0, 0, 16'h7777));
        bus_wr(32'd6, pack(0, 0, 16'h7777));
        bus_wr(32'd0, ctrl(2, 1'b1, 1'b1));
        bus_rd(32'd0, d); check("busy_err", d, 32'h5);
        bus_rd(32'd0, d); check("busy_errclr", d, 32'h1);
        cyc = 0;
        bus_rd(32'd0, d);
        while (d[0] === 1'b1 && cyc < 300) begin
            cyc++;
            bus_rd(32'd0, d);
        end
        check("busy_done", d, 32'h2);
        bus_rd(32'd7, d); check("busy_y", d, 32'h0110);
        bus_rd(32'd8, d); check("busy_h0", d, sx(mh[0]));

        // Randomized programs against the reference model.
        for (int it = 0; it < 5; it++) begin
            do_reset();
            for (int s = 0; s < S; s++) for (int e = 0; e < E; e++) set_arr(1, s, e, rv());
            for (int e = 0; e < E; e++) for (int n = 0; n < H; n++) set_arr(2, e, n, rv());
            for (int m = 0; m < H; m++) for (int n = 0; n < H; n++) set_arr(3, m, n, rv());
            for (int m = 0; m < H; m++) begin
                set_arr(4, 0, m, rv());
                set_arr(5, 0, m, rv());
            end
            set_arr(6, 0, 0, rv());
            run_check($sformatf("rnd%0da", it), (it == 0) ? S : int'($urandom_range(1, 6)),
                      1'b1, 1'($urandom_range(0, 1)));
            run_check($sformatf("rnd%0db", it), int'($urandom_range(1, 4)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
